// File: rtl/matrix_mult_pkg.sv
// Shared definitions for the matrix multiplier and its result sink.
// The state encodings and port widths are common to both blocks.
package matrix_mult_pkg;
  localparam int IW = 5;
  localparam int DW = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/matrix_reg_file.sv
// m*m x DW result storage, row-major addressed.
// It has one synchronous write port, one combinational read port and a synchronous clear.
module matrix_reg_file #(
  parameter int m  = 4,
  parameter int DW = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] wi,
  input  logic [IW-1:0] wj,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] ri,
  input  logic [IW-1:0] rj,
  output logic [DW-1:0] rdata
);
  localparam int N  = m * m;
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic [DW-1:0] mem [N];
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  assign waddr = AW'(int'(wi) * m + int'(wj));
  assign raddr = AW'(int'(ri) * m + int'(rj));
  assign rdata = mem[raddr];

  // Clear has priority so a restart never keeps stale partial sums.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < N; k++) mem[k] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
endmodule

// File: rtl/matrix_result_sink.sv
// Collects strobed results from the sequential multiplier into a register array.
// It then streams the finished matrix out in row-major order over valid/ready.
module matrix_result_sink #(
  parameter int m  = 4,
  parameter int DW = 32,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] z_in,
  input  logic [IW-1:0] z_i,
  input  logic [IW-1:0] z_j,
  input  logic          z_stb,
  output logic          z_ack,
  input  logic          mul_done,
  output logic [DW-1:0] out_data,
  output logic [IW-1:0] out_i,
  output logic [IW-1:0] out_j,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          idx_err,
  output logic [15:0]   wr_count
);
  import matrix_mult_pkg::*;

  // One extra bit so m=32 is representable in the range comparison.
  localparam logic [IW:0]   M_EXT  = (IW+1)'(m);
  localparam logic [IW-1:0] M_LAST = IW'(m - 1);

  state_t        state;
  state_t        state_nxt;
  logic          xfer;
  logic          in_range;
  logic          start_clr;
  logic          hs_last;
  logic          load;
  logic [IW-1:0] rd_i;
  logic [IW-1:0] rd_j;
  logic [DW-1:0] rd_data;

  assign in_range  = ({1'b0, z_i} < M_EXT) && ({1'b0, z_j} < M_EXT);
  assign xfer      = (state == S_COLLECT) && z_stb && !z_ack;
  assign start_clr = start && ((state == S_IDLE) || (state == S_DONE));
  assign hs_last   = out_valid && out_ready && out_last;
  assign load      = (state == S_DRAIN) && (!out_valid || out_ready) && !hs_last;

  matrix_reg_file #(.m(m), .DW(DW), .IW(IW)) u_reg_file (
    .clk   (clk),
    .clr   (rst || start_clr),
    .we    (xfer && in_range),
    .wi    (z_i),
    .wj    (z_j),
    .wdata (z_in),
    .ri    (rd_i),
    .rj    (rd_j),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)    state_nxt = S_COLLECT;
      S_COLLECT: if (mul_done) state_nxt = S_DRAIN;
      S_DRAIN:   if (hs_last)  state_nxt = S_DONE;
      S_DONE:    if (start)    state_nxt = S_COLLECT;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_COLLECT) || (state == S_DRAIN);
  end

  // Capture stage: ack is high for exactly one cycle, which blocks the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_ack    <= 1'b0;
      wr_count <= '0;
      idx_err  <= 1'b0;
    end else begin
      z_ack <= xfer;
      if (start_clr) begin
        wr_count <= '0;
        idx_err  <= 1'b0;
      end else if (xfer) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (!in_range) idx_err <= 1'b1;
      end
    end
  end

  // Drain stage: rd_i/rd_j point at the element to present next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_i      <= '0;
      rd_j      <= '0;
      out_data  <= '0;
      out_i     <= '0;
      out_j     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if ((state == S_COLLECT) && mul_done) begin
      rd_i <= '0;
      rd_j <= '0;
    end else if (load) begin
      out_data  <= rd_data;
      out_i     <= rd_i;
      out_j     <= rd_j;
      out_valid <= 1'b1;
      out_last  <= (rd_i == M_LAST) && (rd_j == M_LAST);
      if (rd_j == M_LAST) begin
        rd_j <= '0;
        rd_i <= rd_i + 1'b1;
      end else begin
        rd_j <= rd_j + 1'b1;
      end
    end else if (hs_last) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_matrix_result_sink.sv
// Directed bench for matrix_result_sink with m=4: capture, overwrite, index error,
// drain back-pressure, back-to-back strobes, same-cycle done and mid-drain reset.
module tb_matrix_result_sink;
  import matrix_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] z_in = '0;
  logic [4:0]  z_i = '0;
  logic [4:0]  z_j = '0;
  logic        z_stb = 1'b0;
  logic        z_ack;
  logic        mul_done = 1'b0;
  logic [31:0] out_data;
  logic [4:0]  out_i;
  logic [4:0]  out_j;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        idx_err;
  logic [15:0] wr_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] dd [16];
  logic [4:0]  di [16];
  logic [4:0]  dj [16];
  logic        dl [16];
  int nwords, first_k, last_k, stall_viol;
  logic drain_done;

  matrix_result_sink #(.m(4), .DW(32), .IW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .z_in(z_in), .z_i(z_i), .z_j(z_j),
    .z_stb(z_stb), .z_ack(z_ack), .mul_done(mul_done), .out_data(out_data),
    .out_i(out_i), .out_j(out_j), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .idx_err(idx_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
  endtask

  // One strobe with the multiplier dropping z_stb after seeing the ack.
  task automatic strobe(input logic [4:0] i, input logic [4:0] j, input logic [31:0] d,
                        output logic a0, output logic a1, output logic a2);
    z_i = i; z_j = j; z_in = d; z_stb = 1'b1;
    a0 = z_ack;
    tick();
    a1 = z_ack;
    z_stb = 1'b0;
    tick();
    a2 = z_ack;
  endtask

  // Accept words with out_ready following pat (bit k%4 in cycle k); bounded.
  task automatic drain(input logic [3:0] pat);
    logic        prev_stall;
    logic [31:0] pd;
    logic [4:0]  pi, pj;
    nwords = 0; stall_viol = 0; first_k = -1; last_k = -1;
    drain_done = 1'b0; prev_stall = 1'b0; pd = '0; pi = '0; pj = '0;
    for (int k = 0; k < 200 && !drain_done; k++) begin
      out_ready = pat[k % 4];
      if (prev_stall && (!out_valid || out_data !== pd || out_i !== pi || out_j !== pj))
        stall_viol++;
      if (out_valid && out_ready) begin
        if (nwords < 16) begin
          dd[nwords] = out_data; di[nwords] = out_i; dj[nwords] = out_j; dl[nwords] = out_last;
        end
        if (first_k < 0) first_k = k;
        last_k = k;
        nwords++;
        if (out_last) drain_done = 1'b1;
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pi = out_i; pj = out_j;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    z_stb = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0; z_stb = 1'b0;
    checks++; if (z_ack !== 1'b0) begin errors++; $display("FAIL rst_z_ack: got %b expected 0", z_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
    checks++; if (out_data !== 32'h0 || out_i !== 5'd0 || out_j !== 5'd0) begin
      errors++; $display("FAIL rst_out_word: got %h (%0d,%0d) expected 0 (0,0)", out_data, out_i, out_j); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL rst_idx_err: got %b expected 0", idx_err); end
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
    tick();
    checks++; if (z_ack !== 1'b0) begin errors++; $display("FAIL idle_stb_no_ack: got %b expected 0", z_ack); end
  endtask

  task automatic test_fill();
    logic a0, a1, a2;
    int bad_ack;
    bad_ack = 0;
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy: got %b expected 1", busy); end
    for (int w = 0; w < 16; w++) begin
      strobe(5'(w / 4), 5'(w % 4), 32'h3F800000 + 32'(w), a0, a1, a2);
      if (a0 !== 1'b0 || a1 !== 1'b1 || a2 !== 1'b0) bad_ack++;
      repeat (4) tick();
    end
    checks++; if (bad_ack != 0) begin errors++; $display("FAIL fill_ack_pulse: got %0d bad pulses expected 0", bad_ack); end
    checks++; if (wr_count !== 16'd16) begin errors++; $display("FAIL fill_wr_count: got %0d expected 16", wr_count); end
    pulse_done();
    drain(4'b1111);
    checks++; if (nwords != 16 || !drain_done) begin errors++; $display("FAIL fill_nwords: got %0d expected 16", nwords); end
    checks++; if (last_k - first_k != 15) begin errors++; $display("FAIL fill_consecutive: got span %0d expected 15", last_k - first_k); end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (dd[w] !== 32'h3F800000 + 32'(w) || di[w] !== 5'(w / 4) || dj[w] !== 5'(w % 4) || dl[w] !== (w == 15)) begin
        errors++;
        $display("FAIL fill_word%0d: got %h (%0d,%0d) last=%b expected %h (%0d,%0d) last=%b",
                 w, dd[w], di[w], dj[w], dl[w], 32'h3F800000 + 32'(w), w / 4, w % 4, (w == 15));
      end
    end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fill_after_busy_valid: got %b %b expected 0 0", busy, out_valid); end
    checks++; if (dut.state !== S_DONE) begin errors++; $display("FAIL fill_state_done: got %0d expected %0d", dut.state, S_DONE); end
  endtask

  task automatic test_overwrite();
    logic a0, a1, a2;
    int nz;
    logic [31:0] vals [4];
    vals[0] = 32'h1; vals[1] = 32'h2; vals[2] = 32'h3; vals[3] = 32'h40400000;
    pulse_start();
    checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL ovw_restart_count: got %0d expected 0", wr_count); end
    for (int n = 0; n < 4; n++) strobe(5'd2, 5'd1, vals[n], a0, a1, a2);
    checks++; if (wr_count !== 16'd4) begin errors++; $display("FAIL ovw_wr_count: got %0d expected 4", wr_count); end
    pulse_done();
    drain(4'b1111);
    checks++; if (nwords != 16) begin errors++; $display("FAIL ovw_nwords: got %0d expected 16", nwords); end
    checks++; if (dd[9] !== 32'h40400000) begin errors++; $display("FAIL ovw_elem21: got %h expected 40400000", dd[9]); end
    nz = 0;
    for (int w = 0; w < 16; w++) if (w != 9 && dd[w] !== 32'h0) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL ovw_others_zero: got %0d nonzero expected 0", nz); end
  endtask

  task automatic test_idx_err();
    logic a0, a1, a2;
    int nz;
    pulse_start();
    checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL idx_cleared: got %b expected 0", idx_err); end
    strobe(5'd5, 5'd0, 32'hDEADBEEF, a0, a1, a2);
    checks++; if (a1 !== 1'b1 || a2 !== 1'b0) begin errors++; $display("FAIL idx_ack: got %b%b expected 10", a1, a2); end
    checks++; if (idx_err !== 1'b1) begin errors++; $display("FAIL idx_err_set: got %b expected 1", idx_err); end
    checks++; if (wr_count !== 16'd1) begin errors++; $display("FAIL idx_wr_count: got %0d expected 1", wr_count); end
    pulse_done();
    drain(4'b1111);
    nz = 0;
    for (int w = 0; w < 16; w++) if (dd[w] !== 32'h0) nz++;
    checks++; if (nz != 0 || nwords != 16) begin errors++; $display("FAIL idx_array_unchanged: got %0d nonzero of %0d expected 0 of 16", nz, nwords); end
    checks++; if (idx_err !== 1'b1) begin errors++; $display("FAIL idx_sticky: got %b expected 1", idx_err); end
  endtask

  task automatic test_stall();
    logic a0, a1, a2;
    pulse_start();
    for (int w = 0; w < 16; w++) strobe(5'(w / 4), 5'(w % 4), 32'hA0000000 + 32'(w * 3), a0, a1, a2);
    pulse_done();
    drain(4'b1001);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stall_viol); end
    checks++; if (nwords != 16 || !drain_done) begin errors++; $display("FAIL stall_nwords: got %0d expected 16", nwords); end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (dd[w] !== 32'hA0000000 + 32'(w * 3) || di[w] !== 5'(w / 4) || dj[w] !== 5'(w % 4)) begin
        errors++;
        $display("FAIL stall_word%0d: got %h (%0d,%0d) expected %h (%0d,%0d)",
                 w, dd[w], di[w], dj[w], 32'hA0000000 + 32'(w * 3), w / 4, w % 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    pulse_start();
    z_i = 5'd0; z_j = 5'd0; z_stb = 1'b1;
    z_in = 32'd11; tick(); acks[0] = z_ack;
    z_in = 32'd22; tick(); acks[1] = z_ack;
    z_in = 32'd33; tick(); acks[2] = z_ack;
    z_in = 32'd44; tick(); acks[3] = z_ack;
    z_stb = 1'b0;
    checks++; if (acks !== 4'b0101) begin errors++; $display("FAIL b2b_ack_seq: got %b expected 0101", acks); end
    checks++; if (wr_count !== 16'd2) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 2", wr_count); end
    pulse_done();
    drain(4'b1111);
    checks++; if (dd[0] !== 32'd33) begin errors++; $display("FAIL b2b_elem00: got %0d expected 33", dd[0]); end
  endtask

  task automatic test_done_same_cycle();
    pulse_start();
    z_i = 5'd3; z_j = 5'd3; z_in = 32'd77; z_stb = 1'b1; mul_done = 1'b1;
    tick();
    z_stb = 1'b0; mul_done = 1'b0;
    checks++; if (z_ack !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL same_ack_entry: got ack=%b valid=%b expected 1 0", z_ack, out_valid); end
    tick();
    checks++; if (z_ack !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL same_ack_drop_first: got ack=%b valid=%b expected 0 1", z_ack, out_valid); end
    drain(4'b1111);
    checks++; if (dd[15] !== 32'd77 || dd[0] !== 32'd0 || wr_count !== 16'd1) begin
      errors++; $display("FAIL same_elem33: got %0d/%0d cnt=%0d expected 77/0 cnt=1", dd[15], dd[0], wr_count); end
  endtask

  task automatic test_reset_mid_drain();
    logic a0, a1, a2;
    logic found;
    int nz;
    pulse_start();
    for (int w = 0; w < 16; w++) strobe(5'(w / 4), 5'(w % 4), 32'h100 + 32'(w), a0, a1, a2);
    pulse_done();
    out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (out_valid && out_i == 5'd1 && out_j == 5'd2) found = 1'b1;
      else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL mid_reach_12: got none expected (1,2) within 40 cycles"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || z_ack !== 1'b0) begin
      errors++; $display("FAIL mid_rst_ctrl: got valid=%b last=%b ack=%b expected 0 0 0", out_valid, out_last, z_ack); end
    checks++; if (out_data !== 32'h0 || out_i !== 5'd0 || out_j !== 5'd0 || busy !== 1'b0 || wr_count !== 16'd0) begin
      errors++; $display("FAIL mid_rst_outputs: got %h (%0d,%0d) busy=%b cnt=%0d expected 0 (0,0) 0 0",
                         out_data, out_i, out_j, busy, wr_count); end
    checks++; if (dut.state !== S_IDLE) begin errors++; $display("FAIL mid_rst_state: got %0d expected %0d", dut.state, S_IDLE); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_no_output: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    pulse_start();
    strobe(5'd3, 5'd2, 32'd99, a0, a1, a2);
    pulse_done();
    drain(4'b1111);
    nz = 0;
    for (int w = 0; w < 16; w++) if (w != 14 && dd[w] !== 32'h0) nz++;
    checks++; if (nz != 0 || dd[14] !== 32'd99 || nwords != 16) begin
      errors++; $display("FAIL mid_restart_drain: got %0d nonzero, elem32=%0d, %0d words expected 0, 99, 16", nz, dd[14], nwords); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    test_reset();
    test_fill();
    test_overwrite();
    test_idx_err();
    test_stall();
    test_back_to_back();
    test_done_same_cycle();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_result_sink.md
Name: matrix_result_sink

Overview:
- Receiving end of the sequential matrix multiplier's result interface (z_out/z_i/z_j/z_stb/z_ack).
- Acknowledges every result strobe and stores the value at result[z_i][z_j] in an m*m x 32-bit register array. Later strobes for the same (i,j), such as partial sums, overwrite earlier ones.
- After the multiplier signals done, streams the completed matrix out in row-major order over a valid/ready port.

Parameters:
- m, 4, matrix dimension (square m x m); 1 <= m <= 32.
- DW, 32, element width (IEEE-754 single bit pattern, treated as opaque bits).
- IW, 5, index port width; fixed to match the multiplier's 5-bit index ports.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new collection; ignored unless in S_IDLE or S_DONE.
- z_in  input  DW  result value (driven by multiplier z_out).
- z_i  input  IW  result row index.
- z_j  input  IW  result column index.
- z_stb  input  1  result valid strobe from multiplier.
- z_ack  output  1  registered one-cycle acknowledge to multiplier.
- mul_done  input  1  one-cycle pulse from multiplier: all products finished.
- out_data  output  DW  drained element.
- out_i  output  IW  row of out_data.
- out_j  output  IW  column of out_data.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_last  output  1  high with the final element (m-1,m-1).
- busy  output  1  high in S_COLLECT or S_DRAIN.
- idx_err  output  1  sticky: a strobe arrived with z_i>=m or z_j>=m.
- wr_count  output  16  number of strobes accepted since start.

Behaviour:
- Reset (sync, rst=1 at clk edge): state=S_IDLE; z_ack=0, out_valid=0, out_last=0, out_data=0, out_i=0, out_j=0, busy=0, idx_err=0, wr_count=0; all array entries cleared to 0. Reset overrides any transfer in progress. A pending ack or drain is dropped with no further output.
- States:
  - S_IDLE: on start -> S_COLLECT; clear array, wr_count, idx_err.
  - S_COLLECT: capture results (rules below). When mul_done=1 -> S_DRAIN; drain pointer=(0,0).
  - S_DRAIN: stream out elements (rules below). After the handshake with out_last=1 -> S_DONE.
  - S_DONE: on start -> S_COLLECT, with the same clears as from S_IDLE.
- Capture rule, S_COLLECT only:
  - Transfer occurs in cycle t when z_stb=1 and z_ack=0.
  - At edge t the array entry [z_i][z_j] <= z_in, z_ack <= 1 (visible in cycle t+1), and wr_count increments, saturating at 16'hFFFF.
  - In cycle t+1, z_ack=1 blocks capture, and z_ack <= 0 at that edge.
  - The multiplier drops z_stb in t+2. If z_stb is still 1 in t+2, that is a new transfer.
  - Throughput: at most one transfer per 2 cycles.
- Out-of-range strobe (z_i>=m or z_j>=m): still acknowledged and counted; array unchanged; idx_err <= 1 (sticky until start or rst).
- Same-cycle z_stb transfer and mul_done: the capture completes first (write + ack). The state moves to S_DRAIN at the same edge, and the z_ack pulse still completes in the next cycle.
- z_stb outside S_COLLECT: ignored, no ack.
- Drain rule, S_DRAIN, registered output:
  - Entry cycle loads element (0,0) into out_data, out_i, out_j and sets out_valid=1. First valid word appears 1 cycle after entering S_DRAIN.
  - out_data, out_i, out_j hold stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready the next element loads in the same edge: j increments, wrapping to 0 at m-1 with i incrementing. One element per cycle when out_ready is held high.
  - out_last=1 exactly when (out_i,out_j)=(m-1,m-1). After that handshake: out_valid=0 and state=S_DONE.
- start in S_COLLECT or S_DRAIN: ignored.
- m=1: the single element is drained with out_last=1 on the first word.

Decomposition:
- Shared package matrix_mult_pkg: state encodings (S_IDLE, S_COLLECT, S_DRAIN, S_DONE), IW=5, DW=32 constants, reused by the multiplier.
- One sub-module: matrix_reg_file. It holds the m*m x DW array with one synchronous write port, one combinational read port, and a synchronous clear.
- The FSM, ack generation and drain counters stay in matrix_result_sink.

Test Plan:
1. rst, start, 16 strobes (i,j)=row-major with z_in=32'h3F800000+idx, 5 idle cycles between, then mul_done -> each z_ack is a single pulse 1 cycle after the strobe; wr_count=16; drain with out_ready=1 gives 16 consecutive words, idx 0..15 values in order; out_last only on word 16; then S_DONE, busy=0.
2. Four strobes to (2,1) with 32'h1, 32'h2, 32'h3, 32'h40400000, then mul_done -> drained element (2,1)=32'h40400000; all others 0; wr_count=4.
3. Strobe with z_i=5 (m=4), z_in=32'hDEADBEEF -> z_ack pulses; idx_err=1; no array entry changes; wr_count=1.
4. Drain with out_ready toggling 1,0,0,1 -> out_data/out_i/out_j stable across stalls; no element skipped or duplicated across all 16 words.
5. z_stb held high for 4 cycles from cycle t -> captures at t and t+2; z_ack high in t+1 and t+3; wr_count=2.
6. rst asserted mid-drain at element (1,2) -> next cycle out_valid=0, state=S_IDLE, all outputs at reset values; a new start plus one strobe plus mul_done drains 0 for every element except the written one.
